dmem_rmw_arb: RTL and testbench

//  Shares the single data memory between two requesters: P0 (processor LSU) and P1 (debug/loader).
//  The memory writes whole words only, so masked stores run as a read-modify-write (RMW) sequence.

---
 rtl/dmem_arb_pkg.sv | 26 ++
 rtl/dmem_arb_sel.sv | 47 ++++
 rtl/dmem_rmw_arb.sv | 214 +++++++++++++++++++++
 tb/tb_dmem_rmw_arb.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types and helpers for the data-memory read-modify-write arbiter.
// Holds the FSM state encoding, the mask constants and the byte-merge function.
package dmem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      WRITE  = 2'd2,
      DONE   = 2'd3
   } state_t;

   localparam logic [3:0] MASK_FULL = 4'hF;
   localparam logic [3:0] MASK_NONE = 4'h0;

   // Per-byte select: a set mask bit takes the byte from new_word, else from old_word.
   function automatic logic [31:0] byte_merge(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  mask);
      logic [31:0] res;
      for (int i = 0; i < 4; i++) begin
         res[8*i +: 8] = mask[i] ? new_word[8*i +: 8] : old_word[8*i +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/dmem_arb_sel.sv
// Two-way grant selection for the data-memory arbiter.
// Build option: DMEM_ARB_RR_EN defined selects round-robin tie breaking;
// otherwise P0 always wins a tie. last_gnt is tracked in both builds.
module dmem_arb_sel (
   input  logic clk,
   input  logic rst,
   input  logic req0,
   input  logic req1,
   input  logic grant_en,
   output logic gnt_port
);

   logic last_gnt_r;
   logic tie_pick_s;

   // Tie-break choice for the configured arbitration scheme
   always_comb begin
`ifdef DMEM_ARB_RR_EN
      tie_pick_s = ~last_gnt_r;
`else
      tie_pick_s = 1'b0;
`endif
   end

   // Port selection: a lone requester wins outright, a tie uses the tie-break choice
   always_comb begin
      if (req0 && req1) begin
         gnt_port = tie_pick_s;
      end else if (req1) begin
         gnt_port = 1'b1;
      end else begin
         gnt_port = 1'b0;
      end
   end

   // Remember the most recently granted port; reset value makes P0 win the first tie
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_gnt_r <= 1'b1;
      end else if (grant_en) begin
         last_gnt_r <= gnt_port;
      end else begin
         last_gnt_r <= last_gnt_r;
      end
   end

endmodule

// File: rtl/dmem_rmw_arb.sv
// Data-memory arbiter for the LSU (P0) and the debug/loader port (P1).
// Masked stores run as read-modify-write since the memory only writes whole words.
// Build option: DMEM_ARB_RR_EN (round-robin arbitration, see dmem_arb_sel).
// TIMEOUT = number of ACCESS cycles without ip_dmem_valid before an error abort; 0 disables.
module dmem_rmw_arb
   import dmem_arb_pkg::*;
#(
   parameter int unsigned TIMEOUT = 15
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ip_p0_req,
   input  logic        ip_p0_wr,
   input  logic [31:0] ip_p0_addr,
   input  logic [3:0]  ip_p0_mask,
   input  logic [31:0] ip_p0_wdata,
   output logic        op_p0_ack,
   output logic        op_p0_err,
   output logic [31:0] op_p0_rdata,
   input  logic        ip_p1_req,
   input  logic        ip_p1_wr,
   input  logic [31:0] ip_p1_addr,
   input  logic [3:0]  ip_p1_mask,
   input  logic [31:0] ip_p1_wdata,
   output logic        op_p1_ack,
   output logic        op_p1_err,
   output logic [31:0] op_p1_rdata,
   output logic [31:0] op_dmem_addr,
   output logic        op_dmem_rd,
   output logic        op_dmem_wr,
   output logic [31:0] op_dmem_wdata,
   input  logic        ip_dmem_valid,
   input  logic [31:0] ip_dmem_rdata
);

   localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   state_t             state_r;
   state_t             state_nx;
   logic               wr_r;
   logic [31:0]        addr_r;
   logic [3:0]         mask_r;
   logic [31:0]        wdata_r;
   logic               port_r;
   logic [31:0]        merged_r;
   logic [CNT_W-1:0]   cnt_r;

   logic               gnt_port_s;
   logic               grant_en_s;
   logic               load_done_s;
   logic               merge_en_s;
   logic               tmo_hit_s;
   logic               cnt_inc_s;
   logic               tmo_last_s;
   logic               sel_wr_s;
   logic [31:0]        sel_addr_s;
   logic [3:0]         sel_mask_s;
   logic [31:0]        sel_wdata_s;

   dmem_arb_sel u_sel (
      .clk      (clk),
      .rst      (rst),
      .req0     (ip_p0_req),
      .req1     (ip_p1_req),
      .grant_en (grant_en_s),
      .gnt_port (gnt_port_s)
   );

   // Abort on the last permitted wait cycle, so exactly TIMEOUT cycles are spent waiting
   assign tmo_last_s = (TIMEOUT != 32'd0) && (cnt_r == CNT_W'(TIMEOUT - 32'd1));

   // Request fields of the port the selector picked
   always_comb begin
      sel_wr_s    = gnt_port_s ? ip_p1_wr    : ip_p0_wr;
      sel_addr_s  = gnt_port_s ? ip_p1_addr  : ip_p0_addr;
      sel_mask_s  = gnt_port_s ? ip_p1_mask  : ip_p0_mask;
      sel_wdata_s = gnt_port_s ? ip_p1_wdata : ip_p0_wdata;
   end

   // FSM next-state and memory-side strobes
   always_comb begin
      state_nx      = state_r;
      op_dmem_rd    = 1'b0;
      op_dmem_wr    = 1'b0;
      op_dmem_wdata = wdata_r;
      grant_en_s    = 1'b0;
      load_done_s   = 1'b0;
      merge_en_s    = 1'b0;
      tmo_hit_s     = 1'b0;
      cnt_inc_s     = 1'b0;
      case (state_r)
         IDLE: begin
            if (ip_p0_req || ip_p1_req) begin
               grant_en_s = 1'b1;
               state_nx   = ACCESS;
            end else begin
               state_nx   = IDLE;
            end
         end
         ACCESS: begin
            op_dmem_rd = 1'b1;
            if (wr_r && (mask_r == MASK_FULL)) begin
               op_dmem_wr = 1'b1;
               state_nx   = DONE;
            end else if (wr_r && (mask_r == MASK_NONE)) begin
               state_nx   = DONE;
            end else if (ip_dmem_valid) begin
               if (wr_r) begin
                  merge_en_s  = 1'b1;
                  state_nx    = WRITE;
               end else begin
                  load_done_s = 1'b1;
                  state_nx    = DONE;
               end
            end else if (tmo_last_s) begin
               tmo_hit_s  = 1'b1;
               state_nx   = DONE;
            end else begin
               cnt_inc_s  = 1'b1;
               state_nx   = ACCESS;
            end
         end
         WRITE: begin
            op_dmem_wr    = 1'b1;
            op_dmem_wdata = merged_r;
            state_nx      = DONE;
         end
         DONE: begin
            state_nx = IDLE;
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

   assign op_dmem_addr = addr_r;

   // FSM state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nx;
      end
   end

   // Capture the granted request for the duration of the transaction
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_r    <= 1'b0;
         addr_r  <= 32'h0000_0000;
         mask_r  <= 4'h0;
         wdata_r <= 32'h0000_0000;
         port_r  <= 1'b0;
      end else if (grant_en_s) begin
         wr_r    <= sel_wr_s;
         addr_r  <= sel_addr_s;
         mask_r  <= sel_mask_s;
         wdata_r <= sel_wdata_s;
         port_r  <= gnt_port_s;
      end
   end

   // Merged word for the write-back half of a partial store
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         merged_r <= 32'h0000_0000;
      end else if (merge_en_s) begin
         merged_r <= byte_merge(ip_dmem_rdata, wdata_r, mask_r);
      end
   end

   // Wait-cycle counter: counts while stalled in ACCESS, zero otherwise
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_r <= '0;
      end else if (cnt_inc_s) begin
         cnt_r <= cnt_r + CNT_W'(1);
      end else begin
         cnt_r <= '0;
      end
   end

   // Completion pulses and error flags, raised for the DONE cycle of the owning port
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_p0_ack <= 1'b0;
         op_p1_ack <= 1'b0;
         op_p0_err <= 1'b0;
         op_p1_err <= 1'b0;
      end else begin
         op_p0_ack <= (state_nx == DONE) && !port_r;
         op_p1_ack <= (state_nx == DONE) &&  port_r;
         op_p0_err <= tmo_hit_s && !port_r;
         op_p1_err <= tmo_hit_s &&  port_r;
      end
   end

   // Load data holding registers, one per port
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_p0_rdata <= 32'h0000_0000;
         op_p1_rdata <= 32'h0000_0000;
      end else if (load_done_s) begin
         if (port_r) begin
            op_p1_rdata <= ip_dmem_rdata;
         end else begin
            op_p0_rdata <= ip_dmem_rdata;
         end
      end
   end

endmodule

// File: tb/tb_dmem_rmw_arb.sv
// Directed bench for dmem_rmw_arb: table of single transactions plus
// hand-written sequences for reset abort, arbitration ties and TIMEOUT=0.
module tb_dmem_rmw_arb;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req0 = 1'b0, wr0 = 1'b0, req1 = 1'b0, wr1 = 1'b0;
   logic [31:0] addr0 = 32'h0, wdata0 = 32'h0, addr1 = 32'h0, wdata1 = 32'h0;
   logic [3:0]  mask0 = 4'h0, mask1 = 4'h0;
   logic        ack0, err0, ack1, err1;
   logic [31:0] rdata0, rdata1;
   logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
   logic        dmem_rd, dmem_wr, dmem_valid;

   // second instance with TIMEOUT=0, read-only use
   logic        inf_req = 1'b0, inf_valid = 1'b0;
   logic        inf_ack0, inf_err0, inf_ack1, inf_err1;
   logic [31:0] inf_rdata0, inf_rdata1, inf_addr, inf_wdata, inf_mem_rdata;
   logic        inf_rd, inf_wr;

   logic [31:0] mem [0:255];
   logic        pre_en = 1'b0;
   logic [7:0]  pre_addr = 8'h0;
   logic [31:0] pre_data = 32'h0;
   int unsigned valid_delay = 0;
   int unsigned rd_cycles = 0;

   int passed = 0;
   int total  = 0;

   always #5 clk = ~clk;

   assign dmem_rdata    = mem[dmem_addr[7:0]];
   assign dmem_valid    = dmem_rd && (rd_cycles >= valid_delay);
   assign inf_mem_rdata = mem[inf_addr[7:0]];

   // memory model: preload port, DUT writes, and a count of consecutive read cycles
   always @(posedge clk) begin
      if (pre_en) mem[pre_addr] <= pre_data;
      else if (dmem_wr) mem[dmem_addr[7:0]] <= dmem_wdata;
      rd_cycles <= dmem_rd ? rd_cycles + 1 : 0;
   end

   dmem_rmw_arb #(.TIMEOUT(15)) u_dut (
      .clk(clk), .rst(rst),
      .ip_p0_req(req0), .ip_p0_wr(wr0), .ip_p0_addr(addr0), .ip_p0_mask(mask0), .ip_p0_wdata(wdata0),
      .op_p0_ack(ack0), .op_p0_err(err0), .op_p0_rdata(rdata0),
      .ip_p1_req(req1), .ip_p1_wr(wr1), .ip_p1_addr(addr1), .ip_p1_mask(mask1), .ip_p1_wdata(wdata1),
      .op_p1_ack(ack1), .op_p1_err(err1), .op_p1_rdata(rdata1),
      .op_dmem_addr(dmem_addr), .op_dmem_rd(dmem_rd), .op_dmem_wr(dmem_wr), .op_dmem_wdata(dmem_wdata),
      .ip_dmem_valid(dmem_valid), .ip_dmem_rdata(dmem_rdata)
   );

   dmem_rmw_arb #(.TIMEOUT(0)) u_dut_inf (
      .clk(clk), .rst(rst),
      .ip_p0_req(inf_req), .ip_p0_wr(wr0), .ip_p0_addr(addr0), .ip_p0_mask(mask0), .ip_p0_wdata(wdata0),
      .op_p0_ack(inf_ack0), .op_p0_err(inf_err0), .op_p0_rdata(inf_rdata0),
      .ip_p1_req(1'b0), .ip_p1_wr(wr1), .ip_p1_addr(addr1), .ip_p1_mask(mask1), .ip_p1_wdata(wdata1),
      .op_p1_ack(inf_ack1), .op_p1_err(inf_err1), .op_p1_rdata(inf_rdata1),
      .op_dmem_addr(inf_addr), .op_dmem_rd(inf_rd), .op_dmem_wr(inf_wr), .op_dmem_wdata(inf_wdata),
      .ip_dmem_valid(inf_valid), .ip_dmem_rdata(inf_mem_rdata)
   );

   typedef struct {
      bit          port;
      bit          wr;
      logic [7:0]  addr;
      logic [3:0]  mask;
      logic [31:0] wdata;
      bit          do_pre;
      logic [31:0] pre;
      int unsigned delay;
      int          exp_cyc;
      int          exp_wr_cnt;
      int          exp_wr_cyc;
      bit          exp_err;
      logic [31:0] exp_rdata;
      logic [31:0] exp_mem;
   } vec_t;

   vec_t vecs [9];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
   endtask

   // called at posedge+1; writes one word into the memory model
   task automatic preload(input logic [7:0] a, input logic [31:0] d);
      pre_addr = a; pre_data = d; pre_en = 1'b1;
      @(posedge clk); #1;
      pre_en = 1'b0;
   endtask

   // called at posedge+1; issues one request and measures it, cycle 0 = request cycle
   task automatic run_req(input vec_t v, output int cyc, output int wr_cnt, output int wr_cyc,
                          output bit err, output int other);
      cyc = -1; wr_cnt = 0; wr_cyc = -1; err = 1'b0; other = 0;
      valid_delay = v.delay;
      if (v.port) begin
         req1 = 1'b1; wr1 = v.wr; addr1 = {24'h0, v.addr}; mask1 = v.mask; wdata1 = v.wdata;
      end else begin
         req0 = 1'b1; wr0 = v.wr; addr0 = {24'h0, v.addr}; mask0 = v.mask; wdata0 = v.wdata;
      end
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (dmem_wr) begin
            wr_cnt++;
            if (wr_cyc < 0) wr_cyc = c;
         end
         if (v.port ? ack0 : ack1) other++;
         if (v.port ? ack1 : ack0) begin
            cyc = c;
            err = v.port ? err1 : err0;
            break;
         end
      end
      @(posedge clk); #1;
      req0 = 1'b0; req1 = 1'b0;
   endtask

   initial begin
      int   cyc, wr_cnt, wr_cyc, other, nack1, found;
      bit   err;
      logic [2:0] exp_seq;
      logic [2:0] got_seq;
      int   ngot;

      //          port wr addr   mask  wdata          pre pre_val        dly  cyc wrn wrc err rdata          mem
      vecs[0] = '{1'b0, 1'b0, 8'h10, 4'h0, 32'h0000_0000, 1'b1, 32'hDEAD_BEEF, 0,   2,  0,  0, 1'b0, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
      vecs[1] = '{1'b1, 1'b1, 8'h20, 4'h5, 32'h1122_3344, 1'b1, 32'hAABB_CCDD, 0,   3,  1,  2, 1'b0, 32'h0000_0000, 32'hAA22_CC44};
      vecs[2] = '{1'b0, 1'b1, 8'h30, 4'hF, 32'hCAFE_F00D, 1'b1, 32'h0000_0000, 255, 2,  1,  1, 1'b0, 32'hDEAD_BEEF, 32'hCAFE_F00D};
      vecs[3] = '{1'b1, 1'b1, 8'h31, 4'h0, 32'hFFFF_FFFF, 1'b1, 32'h1234_5678, 255, 2,  0,  0, 1'b0, 32'h0000_0000, 32'h1234_5678};
      vecs[4] = '{1'b1, 1'b0, 8'h20, 4'h0, 32'h0000_0000, 1'b0, 32'h0000_0000, 3,   5,  0,  0, 1'b0, 32'hAA22_CC44, 32'hAA22_CC44};
      vecs[5] = '{1'b0, 1'b1, 8'h40, 4'hA, 32'h1122_3344, 1'b1, 32'h5566_7788, 2,   5,  1,  4, 1'b0, 32'hDEAD_BEEF, 32'h1166_3388};
      vecs[6] = '{1'b0, 1'b0, 8'h10, 4'h0, 32'h0000_0000, 1'b0, 32'h0000_0000, 255, 16, 0,  0, 1'b1, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
      vecs[7] = '{1'b1, 1'b1, 8'h50, 4'h3, 32'hFFFF_FFFF, 1'b1, 32'h0102_0304, 255, 16, 0,  0, 1'b1, 32'hAA22_CC44, 32'h0102_0304};
      vecs[8] = '{1'b0, 1'b0, 8'h40, 4'h0, 32'h0000_0000, 1'b0, 32'h0000_0000, 0,   2,  0,  0, 1'b0, 32'h1166_3388, 32'h1166_3388};

      // reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset ack0", {31'h0, ack0}, 32'h0);
      chk("reset ack1", {31'h0, ack1}, 32'h0);
      chk("reset err", {30'h0, err0, err1}, 32'h0);
      chk("reset rdata0", rdata0, 32'h0);
      chk("reset rdata1", rdata1, 32'h0);
      chk("reset dmem_rd/wr", {30'h0, dmem_rd, dmem_wr}, 32'h0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;

      // table of single transactions
      for (int i = 0; i < 9; i++) begin
         if (vecs[i].do_pre) preload(vecs[i].addr, vecs[i].pre);
         run_req(vecs[i], cyc, wr_cnt, wr_cyc, err, other);
         chk($sformatf("v%0d ack cycle", i), 32'(cyc), 32'(vecs[i].exp_cyc));
         chk($sformatf("v%0d err", i), {31'h0, err}, {31'h0, vecs[i].exp_err});
         chk($sformatf("v%0d rdata", i), vecs[i].port ? rdata1 : rdata0, vecs[i].exp_rdata);
         chk($sformatf("v%0d write count", i), 32'(wr_cnt), 32'(vecs[i].exp_wr_cnt));
         if (vecs[i].exp_wr_cnt > 0)
            chk($sformatf("v%0d write cycle", i), 32'(wr_cyc), 32'(vecs[i].exp_wr_cyc));
         chk($sformatf("v%0d mem word", i), mem[vecs[i].addr], vecs[i].exp_mem);
         chk($sformatf("v%0d other ack", i), 32'(other), 32'h0);
      end

      // reset asserted during the WRITE cycle of a partial store
      preload(8'h60, 32'h0A0B_0C0D);
      valid_delay = 0;
      req1 = 1'b1; wr1 = 1'b1; addr1 = 32'h60; mask1 = 4'h1; wdata1 = 32'hFFFF_FFFF;
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      chk("rst seq write strobe before reset", {31'h0, dmem_wr}, 32'h1);
      rst = 1'b1; req1 = 1'b0;
      #1;
      chk("rst seq dmem_rd/wr", {30'h0, dmem_rd, dmem_wr}, 32'h0);
      chk("rst seq acks/errs", {28'h0, ack0, ack1, err0, err1}, 32'h0);
      chk("rst seq rdata0", rdata0, 32'h0);
      chk("rst seq rdata1", rdata1, 32'h0);
      nack1 = 0;
      repeat (2) begin
         @(negedge clk);
         if (ack1) nack1++;
      end
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (3) begin
         @(negedge clk);
         if (ack1) nack1++;
      end
      chk("rst seq no ack", 32'(nack1), 32'h0);
      chk("rst seq word unchanged", mem[8'h60], 32'h0A0B_0C0D);
      @(posedge clk); #1;

      // both requesters held: grant order of the first three completions
`ifdef DMEM_ARB_RR_EN
      exp_seq = 3'b010;
`else
      exp_seq = 3'b000;
`endif
      valid_delay = 0;
      req0 = 1'b1; wr0 = 1'b0; addr0 = 32'h10;
      req1 = 1'b1; wr1 = 1'b0; addr1 = 32'h20;
      got_seq = 3'b000; ngot = 0;
      for (int c = 0; c < 60 && ngot < 3; c++) begin
         @(negedge clk);
         if (ack0 || ack1) begin
            got_seq[2 - ngot] = ack1;
            ngot++;
         end
      end
      @(posedge clk); #1;
      req0 = 1'b0; req1 = 1'b0;
      chk("tie grant count", 32'(ngot), 32'h3);
      chk("tie grant order", {29'h0, got_seq}, {29'h0, exp_seq});
      chk("tie p0 rdata", rdata0, 32'hDEAD_BEEF);
      repeat (2) @(posedge clk);
      #1;

      // TIMEOUT=0 instance waits indefinitely, then completes on valid
      addr0 = 32'h10; wr0 = 1'b0; mask0 = 4'h0;
      inf_req = 1'b1; inf_valid = 1'b0;
      nack1 = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (inf_ack0) nack1++;
      end
      chk("inf no ack while waiting", 32'(nack1), 32'h0);
      chk("inf still reading", {31'h0, inf_rd}, 32'h1);
      @(posedge clk); #1;
      inf_valid = 1'b1;
      found = -1;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         if (inf_ack0) begin
            found = c;
            chk("inf err", {31'h0, inf_err0}, 32'h0);
            break;
         end
      end
      chk("inf ack after valid", 32'(found), 32'h1);
      chk("inf rdata", inf_rdata0, 32'hDEAD_BEEF);
      @(posedge clk); #1;
      inf_req = 1'b0; inf_valid = 1'b0;
      repeat (2) @(posedge clk);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
